// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch PC with inc/branch/JALR/return select and circular return-address stack
// Optional PC_MISALIGN_TRAP_EN: redirects misaligned next-PC targets to TRAP_VECTOR and pulses misalign.
module pc_unit #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = 32'h0000_0000,
`ifdef PC_MISALIGN_TRAP_EN
  parameter logic [ADDRESS_WIDTH-1:0] TRAP_VECTOR   = 32'h0000_0100,
`endif
  parameter int                       IMM_SHIFT     = 1,
  parameter int                       RAS_DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic [1:0]                   PCsrc,
  input  logic                         link,
  input  logic [ADDRESS_WIDTH-1:0]     ImmOp,
  input  logic [ADDRESS_WIDTH-1:0]     rs1,
  output logic [ADDRESS_WIDTH-1:0]     PC,
  output logic [ADDRESS_WIDTH-1:0]     inc_PC,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
`ifdef PC_MISALIGN_TRAP_EN
  output logic                         misalign,
`endif
  output logic                         ras_underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic [ADDRESS_WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [ADDRESS_WIDTH-1:0] ras_d [RAS_DEPTH];
  logic [PTR_W-1:0]         ptr_q, ptr_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     underflow_q, underflow_d;
`ifdef PC_MISALIGN_TRAP_EN
  logic                     misalign_q, misalign_d;
`endif

  logic [ADDRESS_WIDTH-1:0] branch_pc;
  logic [ADDRESS_WIDTH-1:0] jalr_pc;
  logic [ADDRESS_WIDTH-1:0] next_pc;
  logic [PTR_W-1:0]         ptr_inc;
  logic                     push;
  logic                     pop;

  assign inc_PC = pc_q + ADDRESS_WIDTH'(4);

  always_comb begin
    branch_pc = pc_q + (ImmOp << IMM_SHIFT);
    jalr_pc   = (rs1 + ImmOp) & ~ADDRESS_WIDTH'(1);
    ptr_inc   = ptr_q + PTR_W'(1);
    push      = link && (PCsrc == 2'b01 || PCsrc == 2'b10);
    pop       = (PCsrc == 2'b11) && (cnt_q != '0);

    case (PCsrc)
      2'b01:   next_pc = branch_pc;
      2'b10:   next_pc = jalr_pc;
      2'b11:   next_pc = pop ? ras_q[ptr_q] : inc_PC;
      default: next_pc = inc_PC;
    endcase

    pc_d        = pc_q;
    ras_d       = ras_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    underflow_d = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    misalign_d  = 1'b0;
`endif

    if (!stall) begin
      pc_d        = next_pc;
      underflow_d = (PCsrc == 2'b11) && (cnt_q == '0);
      // A push into a full stack wraps the pointer onto the oldest entry.
      if (push) begin
        ras_d[ptr_inc] = inc_PC;
        ptr_d          = ptr_inc;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      end else if (pop) begin
        ptr_d = ptr_q - PTR_W'(1);
        cnt_d = cnt_q - CNT_W'(1);
      end
`ifdef PC_MISALIGN_TRAP_EN
      if (next_pc[1:0] != 2'b00) begin
        pc_d       = TRAP_VECTOR;
        misalign_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_VECTOR;
      ptr_q       <= '0;
      cnt_q       <= '0;
      underflow_q <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      misalign_q  <= 1'b0;
`endif
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      pc_q        <= pc_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      underflow_q <= underflow_d;
`ifdef PC_MISALIGN_TRAP_EN
      misalign_q  <= misalign_d;
`endif
      ras_q       <= ras_d;
    end
  end

  assign PC            = pc_q;
  assign ras_count     = cnt_q;
  assign ras_underflow = underflow_q;
`ifdef PC_MISALIGN_TRAP_EN
  assign misalign      = misalign_q;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - scoreboard bench for pc_unit with directed call/return/stall vectors
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [1:0]  PCsrc = 2'b00;
  logic        link = 1'b0;
  logic [31:0] ImmOp = '0;
  logic [31:0] rs1 = '0;
  logic [31:0] PC;
  logic [31:0] inc_PC;
  logic [2:0]  ras_count;
  logic        ras_underflow;
`ifdef PC_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  pc_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .PCsrc(PCsrc), .link(link),
    .ImmOp(ImmOp), .rs1(rs1), .PC(PC), .inc_PC(inc_PC),
    .ras_count(ras_count),
`ifdef PC_MISALIGN_TRAP_EN
    .misalign(misalign),
`endif
    .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] pc;
    int          cnt;
    logic        uf;
    logic        mis;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
    end
  endtask

  // One vector per cycle: drive on the falling edge, expectation is for after the next rising edge.
  task automatic step(input logic r, input logic s, input logic [1:0] src, input logic lk,
                      input logic [31:0] imm, input logic [31:0] r1,
                      input logic [31:0] epc, input int ecnt, input logic euf,
                      input logic emis, input string nm);
    exp_t e;
    @(negedge clk);
    rst = r; stall = s; PCsrc = src; link = lk; ImmOp = imm; rs1 = r1;
    e.name = nm; e.pc = epc; e.cnt = ecnt; e.uf = euf; e.mis = emis;
    sb_q.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({e.name, ".pc"}, PC, e.pc);
      chk({e.name, ".inc_pc"}, inc_PC, e.pc + 32'd4);
      chk({e.name, ".ras_count"}, {29'd0, ras_count}, e.cnt);
      chk({e.name, ".underflow"}, {31'd0, ras_underflow}, {31'd0, e.uf});
`ifdef PC_MISALIGN_TRAP_EN
      chk({e.name, ".misalign"}, {31'd0, misalign}, {31'd0, e.mis});
`endif
    end
  end

  initial begin
    int wait_cycles;
    step(1, 0, 2'b00, 0, 32'h0, 32'h0, 32'h0,  0, 0, 0, "reset");
    step(0, 0, 2'b00, 0, 32'h0, 32'h0, 32'h4,  0, 0, 0, "inc1");
    step(0, 0, 2'b00, 0, 32'h0, 32'h0, 32'h8,  0, 0, 0, "inc2");
    step(0, 0, 2'b00, 0, 32'h0, 32'h0, 32'hC,  0, 0, 0, "inc3");
    step(1, 0, 2'b01, 1, 32'h8, 32'h0, 32'h0,  0, 0, 0, "mid_reset");
    for (int i = 1; i <= 4; i++)
      step(0, 0, 2'b00, 0, 32'h0, 32'h0, 32'(4 * i), 0, 0, 0, "walk");
    step(0, 1, 2'b01, 0, 32'hFFFF_FFFC, 32'h0, 32'h10, 0, 0, 0, "stall_branch");
    step(0, 0, 2'b01, 0, 32'hFFFF_FFFC, 32'h0, 32'h08, 0, 0, 0, "branch_back");
    step(0, 0, 2'b01, 0, 32'h0000_000C, 32'h0, 32'h20, 0, 0, 0, "branch_fwd");
    step(0, 0, 2'b10, 1, 32'h4, 32'h101, 32'h104, 1, 0, 0, "jalr_call");
    step(0, 0, 2'b11, 0, 32'h0, 32'h0,   32'h24,  0, 0, 0, "return");
    step(0, 0, 2'b01, 0, 32'hE, 32'h0,   32'h40,  0, 0, 0, "to_0x40");
    step(0, 0, 2'b11, 0, 32'h0, 32'h0,   32'h44,  0, 1, 0, "empty_pop");
    step(0, 0, 2'b00, 0, 32'h0, 32'h0,   32'h48,  0, 0, 0, "uf_clear");
    step(1, 0, 2'b00, 0, 32'h0, 32'h0,   32'h0,   0, 0, 0, "reset2");
    step(0, 0, 2'b10, 1, 32'h0, 32'h100, 32'h100, 1, 0, 0, "call1");
    step(0, 0, 2'b10, 1, 32'h0, 32'h200, 32'h200, 2, 0, 0, "call2");
    step(0, 0, 2'b10, 1, 32'h0, 32'h300, 32'h300, 3, 0, 0, "call3");
    step(0, 0, 2'b10, 1, 32'h0, 32'h400, 32'h400, 4, 0, 0, "call4");
    step(0, 0, 2'b10, 1, 32'h0, 32'h800, 32'h800, 4, 0, 0, "call5_full");
    step(0, 0, 2'b11, 0, 32'h0, 32'h0, 32'h404, 3, 0, 0, "ret1");
    step(0, 0, 2'b11, 0, 32'h0, 32'h0, 32'h304, 2, 0, 0, "ret2");
    step(0, 0, 2'b11, 0, 32'h0, 32'h0, 32'h204, 1, 0, 0, "ret3");
    step(0, 0, 2'b11, 0, 32'h0, 32'h0, 32'h104, 0, 0, 0, "ret4");
    step(0, 0, 2'b11, 0, 32'h0, 32'h0, 32'h108, 0, 1, 0, "ret5_lost");
    step(0, 0, 2'b00, 1, 32'h0, 32'h0, 32'h10C, 0, 0, 0, "link_inc_ignored");
    step(0, 0, 2'b11, 0, 32'h0, 32'h0, 32'h110, 0, 1, 0, "no_push_seen");
    step(0, 0, 2'b10, 1, 32'h0, 32'h500, 32'h500, 1, 0, 0, "call6");
    step(0, 1, 2'b11, 0, 32'h0, 32'h0, 32'h500, 1, 0, 0, "stall_ret");
    step(0, 1, 2'b10, 1, 32'h0, 32'h900, 32'h500, 1, 0, 0, "stall_call");
    step(0, 0, 2'b11, 0, 32'h0, 32'h0, 32'h114, 0, 0, 0, "ret6");
`ifdef PC_MISALIGN_TRAP_EN
    step(1, 0, 2'b00, 0, 32'h0, 32'h0, 32'h0,   0, 0, 0, "reset3");
    step(0, 0, 2'b01, 0, 32'h1, 32'h0, 32'h100, 0, 0, 1, "misalign_trap");
    step(0, 0, 2'b00, 0, 32'h0, 32'h0, 32'h104, 0, 0, 0, "misalign_clear");
`endif
    @(negedge clk);
    rst = 1'b0; stall = 1'b0; PCsrc = 2'b00; link = 1'b0;
    wait_cycles = 0;
    while (sb_q.size() > 0 && wait_cycles < 20) begin
      @(negedge clk);
      wait_cycles++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
